register_file_sb: RTL and testbench

- Parametrised multi-write-port integer register file with a per-register busy scoreboard and optional same-cycle write-to-read bypass.
- Sits in the CPU core between decode/issue and the writeback stage.
- Serves decode operand reads and lets issue reserve a destination register for multi-cycle units (load, mul/div).
- Writeback clears the busy bit. x0 is hardwired to zero. A trap request suppresses all state updates and flushes the scoreboard.

---
 rtl/register_file_sb.sv | 153 +++++++++++++++
 tb/tb_register_file_sb.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/register_file_sb.sv
// register_file_sb
//   Integer register file with several write ports, a per-register busy
//   scoreboard and optional same-cycle write-to-read forwarding. It sits
//   between decode/issue and writeback. x0 always reads as zero. A trap
//   cancels all writes and reservations and flushes the scoreboard.
//
// Ports
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_we          per-write-port enable
//   i_waddr       write addresses
//   i_wdata       write data
//   i_raddr       read addresses
//   o_rdata       read data (combinational)
//   o_rbusy       read operand still has a pending producer (combinational)
//   i_rsv_valid   request to mark i_rsv_addr busy
//   i_rsv_addr    destination register to reserve
//   o_rsv_ready   reservation can be taken this cycle (not already busy)
//   i_trap_req    suppress writes and reservations, clear all busy bits
//   o_wconflict   two or more effective writes hit the same register
module register_file_sb #(
  parameter int XLEN     = 32,
  parameter int N_REGS   = 32,
  parameter int N_RPORTS = 2,
  parameter int N_WPORTS = 2,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(N_REGS)
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [N_WPORTS-1:0]                i_we,
  input  logic [N_WPORTS-1:0][AW-1:0]        i_waddr,
  input  logic [N_WPORTS-1:0][XLEN-1:0]      i_wdata,
  input  logic [N_RPORTS-1:0][AW-1:0]        i_raddr,
  output logic [N_RPORTS-1:0][XLEN-1:0]      o_rdata,
  output logic [N_RPORTS-1:0]                o_rbusy,
  input  logic                               i_rsv_valid,
  input  logic [AW-1:0]                      i_rsv_addr,
  output logic                               o_rsv_ready,
  input  logic                               i_trap_req,
  output logic                               o_wconflict
);

  // Storage for x1..x(N_REGS-1); x0 has no flops.
  logic [XLEN-1:0]   r_regs [1:N_REGS-1];
  logic [N_REGS-1:1] r_busy;

  logic [N_WPORTS-1:0] w_eff;
  logic [N_REGS-1:0]   w_wr_en;
  logic [XLEN-1:0]     w_wr_data [N_REGS];
  logic [XLEN-1:0]     w_rf      [N_REGS];
  logic [N_REGS-1:0]   w_busy;
  logic [N_REGS-1:1]   w_busy_nxt;
  logic                w_rsv_accept;

  // A write is effective only if enabled, not to x0 and not during a trap.
  always_comb begin
    for (int k = 0; k < N_WPORTS; k++) begin
      w_eff[k] = i_we[k] && (i_waddr[k] != '0) && !i_trap_req;
    end
  end

  // Per-register write enable and winning data. Ports are scanned in
  // ascending order so the highest-indexed port overrides lower ones.
  // NOTE: every combinational output gets a default before the loop;
  // otherwise registers no port targets would keep old values (a latch).
  always_comb begin
    w_wr_en = '0;
    for (int a = 0; a < N_REGS; a++) begin
      w_wr_data[a] = '0;
    end
    for (int k = 0; k < N_WPORTS; k++) begin
      if (w_eff[k]) begin
        w_wr_en[i_waddr[k]]   = 1'b1;
        w_wr_data[i_waddr[k]] = i_wdata[k];
      end
    end
  end

  always_comb begin
    o_wconflict = 1'b0;
    for (int i = 0; i < N_WPORTS; i++) begin
      for (int j = i + 1; j < N_WPORTS; j++) begin
        if (w_eff[i] && w_eff[j] && (i_waddr[i] == i_waddr[j])) begin
          o_wconflict = 1'b1;
        end
      end
    end
  end

  // Full-width views with the constant x0 entry folded in, so any address
  // can index them directly.
  always_comb begin
    w_rf[0] = '0;
    for (int a = 1; a < N_REGS; a++) begin
      w_rf[a] = r_regs[a];
    end
  end
  assign w_busy = {r_busy, 1'b0};

  assign o_rsv_ready  = !w_busy[i_rsv_addr];
  assign w_rsv_accept = i_rsv_valid && o_rsv_ready && !i_trap_req &&
                        (i_rsv_addr != '0);

  // Reservation beats a same-cycle write: the write is an older producer,
  // the reservation announces a newer one still in flight.
  always_comb begin
    for (int a = 1; a < N_REGS; a++) begin
      if (i_trap_req) begin
        w_busy_nxt[a] = 1'b0;
      end else if (w_rsv_accept && (i_rsv_addr == AW'(a))) begin
        w_busy_nxt[a] = 1'b1;
      end else if (w_wr_en[a]) begin
        w_busy_nxt[a] = 1'b0;
      end else begin
        w_busy_nxt[a] = r_busy[a];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  // NOTE: the register array is architecturally reset to zero, so it is
  // built from resettable flops rather than an inferred RAM.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
      for (int a = 1; a < N_REGS; a++) begin
        r_regs[a] <= '0;
      end
    end else begin
      r_busy <= w_busy_nxt;
      for (int a = 1; a < N_REGS; a++) begin
        if (w_wr_en[a]) begin
          r_regs[a] <= w_wr_data[a];
        end
      end
    end
  end

  // Reads: stored value, optionally replaced by this cycle's winning write.
  // During a trap w_wr_en is all zero, so no forwarding happens.
  always_comb begin
    for (int j = 0; j < N_RPORTS; j++) begin
      o_rdata[j] = w_rf[i_raddr[j]];
      o_rbusy[j] = w_busy[i_raddr[j]];
      if ((BYPASS != 0) && w_wr_en[i_raddr[j]]) begin
        o_rdata[j] = w_wr_data[i_raddr[j]];
        o_rbusy[j] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_register_file_sb.sv
module tb_register_file_sb;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [1:0]      i_we;
  logic [1:0][4:0] i_waddr;
  logic [1:0][31:0] i_wdata;
  logic [1:0][4:0] i_raddr;
  logic            i_rsv_valid;
  logic [4:0]      i_rsv_addr;
  logic            i_trap_req;

  logic [1:0][31:0] o_rdata,  nb_rdata;
  logic [1:0]       o_rbusy,  nb_rbusy;
  logic             o_rsv_ready, nb_rsv_ready;
  logic             o_wconflict, nb_wconflict;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  register_file_sb #(.BYPASS(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_raddr(i_raddr), .o_rdata(o_rdata),
    .o_rbusy(o_rbusy), .i_rsv_valid(i_rsv_valid), .i_rsv_addr(i_rsv_addr),
    .o_rsv_ready(o_rsv_ready), .i_trap_req(i_trap_req),
    .o_wconflict(o_wconflict)
  );

  register_file_sb #(.BYPASS(0)) dut_nb (
    .i_clk(i_clk), .i_rst(i_rst), .i_we(i_we), .i_waddr(i_waddr),
    .i_wdata(i_wdata), .i_raddr(i_raddr), .o_rdata(nb_rdata),
    .o_rbusy(nb_rbusy), .i_rsv_valid(i_rsv_valid), .i_rsv_addr(i_rsv_addr),
    .o_rsv_ready(nb_rsv_ready), .i_trap_req(i_trap_req),
    .o_wconflict(nb_wconflict)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic idle();
    i_we        = '0;
    i_waddr     = '0;
    i_wdata     = '0;
    i_raddr     = '0;
    i_rsv_valid = 1'b0;
    i_rsv_addr  = '0;
    i_trap_req  = 1'b0;
  endtask

  // Advance one clock edge; inputs change and outputs settle away from it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input int port, input logic [4:0] a,
                    input logic [31:0] d);
    i_we[port]    = 1'b1;
    i_waddr[port] = a;
    i_wdata[port] = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    i_rsv_valid = 1'b1;
    i_rsv_addr  = a;
  endtask

  initial begin
    idle();
    i_rst = 1'b1;
    tick();
    tick();
    i_rst = 1'b0;

    // Reset state.
    i_raddr[0] = 5'd5; i_rsv_addr = 5'd5; #1;
    check("rst_rdata",  o_rdata[0],  32'h0);
    check("rst_rbusy",  o_rbusy[0],  32'h0);
    check("rst_ready",  o_rsv_ready, 32'h1);
    check("rst_wconf",  o_wconflict, 32'h0);

    // Basic write then read on the other port.
    idle(); wr(0, 5'd5, 32'hDEADBEEF); tick();
    idle(); i_raddr[1] = 5'd5; i_raddr[0] = 5'd0; #1;
    check("x5_rdata",   o_rdata[1],  32'hDEADBEEF);
    check("x5_rbusy",   o_rbusy[1],  32'h0);
    check("x0_rdata",   o_rdata[0],  32'h0);

    // Same-cycle bypass vs. stored-only build.
    idle(); wr(0, 5'd7, 32'h12345678); i_raddr[0] = 5'd7; #1;
    check("byp_x7",     o_rdata[0],  32'h12345678);
    check("nobyp_x7",   nb_rdata[0], 32'h0);
    tick();
    idle(); i_raddr[0] = 5'd7; #1;
    check("nobyp_x7_nx", nb_rdata[0], 32'h12345678);

    // Two ports writing the same register: higher port wins.
    idle(); wr(0, 5'd3, 32'h11); wr(1, 5'd3, 32'h22); i_raddr[0] = 5'd3; #1;
    check("conf_flag",  o_wconflict, 32'h1);
    check("conf_byp",   o_rdata[0],  32'h22);
    tick();
    idle(); i_raddr[0] = 5'd3; #1;
    check("conf_x3",    o_rdata[0],  32'h22);

    // Both ports to x0: no conflict, x0 stays zero.
    idle(); wr(0, 5'd0, 32'hFF); wr(1, 5'd0, 32'hEE); #1;
    check("x0_conf",    o_wconflict, 32'h0);
    check("x0_byp",     o_rdata[0],  32'h0);
    tick();
    idle(); #1;
    check("x0_after",   o_rdata[0],  32'h0);

    // Different addresses: no conflict.
    idle(); wr(0, 5'd10, 32'h1); wr(1, 5'd11, 32'h2); #1;
    check("noconf",     o_wconflict, 32'h0);
    tick();

    // Reservation, WAW stall, writeback clears.
    idle(); rsv(5'd9); #1;
    check("rsv9_ready", o_rsv_ready, 32'h1);
    tick();
    idle(); i_raddr[0] = 5'd9; rsv(5'd9); #1;
    check("x9_busy",    o_rbusy[0],  32'h1);
    check("x9_stall",   o_rsv_ready, 32'h0);
    tick();
    idle(); wr(0, 5'd9, 32'hAB); i_raddr[0] = 5'd9; #1;
    check("x9_wb_rbusy", o_rbusy[0], 32'h0);
    check("x9_wb_data",  o_rdata[0], 32'hAB);
    check("x9_nb_rbusy", nb_rbusy[0], 32'h1);
    tick();
    idle(); i_raddr[0] = 5'd9; i_rsv_addr = 5'd9; #1;
    check("x9_clr_busy", o_rbusy[0],  32'h0);
    check("x9_clr_rdy",  o_rsv_ready, 32'h1);
    check("x9_clr_data", o_rdata[0],  32'hAB);

    // Reservation and write to same register: reservation wins.
    idle(); rsv(5'd4); wr(1, 5'd4, 32'h55); tick();
    idle(); i_raddr[0] = 5'd4; #1;
    check("x4_data",    o_rdata[0],  32'h55);
    check("x4_busy",    o_rbusy[0],  32'h1);

    // Trap: suppresses the write and flushes the scoreboard.
    idle(); rsv(5'd2); wr(0, 5'd2, 32'h10); tick();
    idle(); rsv(5'd6); wr(0, 5'd6, 32'h77); tick();
    idle(); i_trap_req = 1'b1; wr(0, 5'd2, 32'h99); rsv(5'd12);
    i_raddr[0] = 5'd2; i_raddr[1] = 5'd6; #1;
    check("trap_rdata", o_rdata[0],  32'h10);
    check("trap_rbusy", o_rbusy[0],  32'h1);
    check("trap_wconf", o_wconflict, 32'h0);
    tick();
    idle(); i_raddr[0] = 5'd2; i_raddr[1] = 5'd6; #1;
    check("post_trap_x2",    o_rdata[0], 32'h10);
    check("post_trap_b2",    o_rbusy[0], 32'h0);
    check("post_trap_b6",    o_rbusy[1], 32'h0);
    i_raddr[0] = 5'd4; i_raddr[1] = 5'd12; #1;
    check("post_trap_b4",    o_rbusy[0], 32'h0);
    check("post_trap_b12",   o_rbusy[1], 32'h0);

    // Reset mid-operation with x6 busy, holding 0x77, and writes pending.
    idle(); rsv(5'd6); tick();
    idle(); i_raddr[0] = 5'd6; #1;
    check("pre_rst_b6", o_rbusy[0],  32'h1);
    check("pre_rst_x6", o_rdata[0],  32'h77);
    idle(); i_rst = 1'b1; wr(0, 5'd6, 32'h77); wr(1, 5'd8, 32'h88); rsv(5'd13);
    tick();
    i_rst = 1'b0; idle();
    for (int r = 0; r < 32; r++) begin
      i_raddr[0] = 5'(r); i_rsv_addr = 5'(r); #1;
      check($sformatf("rst2_x%0d", r),   o_rdata[0],  32'h0);
      check($sformatf("rst2_b%0d", r),   o_rbusy[0],  32'h0);
      check($sformatf("rst2_rdy%0d", r), o_rsv_ready, 32'h1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
